hs_npu_systolic_feeder: RTL and testbench

//  Transmit side of the systolic-array operand interface. Accepts one unskewed vector of SIZE
//  16-bit operands per beat over valid/ready. Drives the array edge input with lane k delayed k

---
 rtl/hs_npu_systolic_feeder_if.sv | 36 +++
 rtl/hs_npu_systolic_feeder.sv | 137 +++++++++++++
 tb/tb_hs_npu_systolic_feeder.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_npu_systolic_feeder_if.sv
// Operand-feeder bus: unskewed vector stream in, diagonally skewed array-edge data out.
// Carries beat_count only when HS_NPU_FEEDER_BEAT_COUNT_EN is defined.
interface hs_npu_systolic_feeder_if #(
   parameter int SIZE  = 8,
   parameter int CNT_W = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [SIZE-1:0][15:0] in_data;
   logic                  in_last;
   logic [SIZE-1:0][15:0] out_data;
   logic                  enable_out;
   logic                  busy;
   logic                  done;
`ifdef HS_NPU_FEEDER_BEAT_COUNT_EN
   logic [CNT_W-1:0]      beat_count;

   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, out_data, enable_out, busy, done, beat_count
   );
   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, out_data, enable_out, busy, done, beat_count
   );
`else
   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, out_data, enable_out, busy, done
   );
   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, out_data, enable_out, busy, done
   );
`endif
endinterface

// File: rtl/hs_npu_systolic_feeder.sv
// Systolic-array operand feeder: lane k delayed k beats, zero flush after the last beat.
// Optional HS_NPU_FEEDER_BEAT_COUNT_EN adds a saturating per-stream beat counter.
module hs_npu_systolic_feeder #(
   parameter int SIZE  = 8,
   parameter int CNT_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   hs_npu_systolic_feeder_if.slave bus
);
   localparam int FW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [FW-1:0] FLUSH_LAST = FW'((SIZE > 1) ? (SIZE - 2) : 0);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

   state_t                state_reg, state_next;
   logic [FW-1:0]         flush_cnt_reg, flush_cnt_next;
   logic                  done_reg, done_next;
   logic                  enable_reg;
   logic                  in_ready_int;
   logic                  accept;
   logic                  advance;
   logic [SIZE-1:0][15:0] feed;

   // in_ready is forced low while reset is asserted, even though state is IDLE
   assign in_ready_int = rst_n & (state_reg != FLUSH);
   assign accept       = bus.in_valid & in_ready_int;
   assign advance      = accept | (state_reg == FLUSH);
   assign feed         = (state_reg == FLUSH) ? '0 : bus.in_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         flush_cnt_reg <= '0;
         done_reg      <= 1'b0;
         enable_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         flush_cnt_reg <= flush_cnt_next;
         done_reg      <= done_next;
         enable_reg    <= advance;
      end
   end

   always_comb begin
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      done_next      = 1'b0;
      case (state_reg)
         IDLE, STREAM: begin
            if (accept) begin
               if (bus.in_last) begin
                  if (SIZE > 1) begin
                     state_next     = FLUSH;
                     flush_cnt_next = '0;
                  end else begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end else begin
                  state_next = STREAM;
               end
            end
         end
         FLUSH: begin
            if (flush_cnt_reg == FLUSH_LAST) begin
               state_next     = IDLE;
               flush_cnt_next = '0;
               done_next      = 1'b1;
            end else begin
               flush_cnt_next = flush_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next     = IDLE;
            flush_cnt_next = '0;
         end
      endcase
   end

   // Lane gi: gi skew stages feeding one output register, all shifting only on advance
   for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
      logic [15:0] lane_out_reg;

      if (gi == 0) begin : g_direct
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               lane_out_reg <= '0;
            end else if (advance) begin
               lane_out_reg <= feed[gi];
            end
         end
      end else begin : g_skewed
         logic [15:0] skew_reg [gi];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int j = 0; j < gi; j++) begin
                  skew_reg[j] <= '0;
               end
               lane_out_reg <= '0;
            end else if (advance) begin
               skew_reg[0] <= feed[gi];
               for (int j = 1; j < gi; j++) begin
                  skew_reg[j] <= skew_reg[j-1];
               end
               lane_out_reg <= skew_reg[gi-1];
            end
         end
      end

      assign bus.out_data[gi] = lane_out_reg;
   end

`ifdef HS_NPU_FEEDER_BEAT_COUNT_EN
   logic [CNT_W-1:0] beat_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_count_reg <= '0;
      end else if (accept) begin
         if (state_reg == IDLE) begin
            beat_count_reg <= CNT_W'(1);
         end else if (beat_count_reg != {CNT_W{1'b1}}) begin
            beat_count_reg <= beat_count_reg + 1'b1;
         end
      end
   end

   assign bus.beat_count = beat_count_reg;
`endif

   assign bus.in_ready   = in_ready_int;
   assign bus.enable_out = enable_reg;
   assign bus.busy       = (state_reg != IDLE);
   assign bus.done       = done_reg;
endmodule

// File: tb/tb_hs_npu_systolic_feeder.sv
// Self-checking bench for hs_npu_systolic_feeder (SIZE=4): expected-vector table plus
// scoreboard of skewed outputs built from the stimulus.
module tb_hs_npu_systolic_feeder;
   localparam int SIZE = 4;
   typedef logic [SIZE-1:0][15:0] vec_t;

   typedef struct {
      logic [15:0] exp_lane0;
      logic [15:0] exp_lane3;
   } row_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   hs_npu_systolic_feeder_if #(.SIZE(SIZE), .CNT_W(16)) bus ();

   hs_npu_systolic_feeder #(.SIZE(SIZE), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   pass_cnt = 0;
   int   total_cnt = 0;
   vec_t sb[$];
   vec_t cap[$];
   vec_t stim_beats[16];
   int   stim_gap[16];
   vec_t prev_out;
   int   cyc = 0;
   int   enable_cnt = 0;
   int   done_cnt = 0;
   int   busy_cnt = 0;
   int   first_en = -1;
   int   last_en = -1;
   int   done_cyc = -1;
   bit   first_accept_done;
   bit   bc_check = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every enabled cycle pops one expected vector; stalled cycles must hold
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         prev_out = '0;
      end else begin
         if (bus.enable_out) begin
            cap.push_back(bus.out_data);
            enable_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (sb.size() == 0) begin
               chk("sb_underflow", 64'd1, 64'd0);
            end else begin
               chk("sb_out", bus.out_data, sb.pop_front());
            end
         end else begin
            chk("hold_out", bus.out_data, prev_out);
         end
         prev_out = bus.out_data;
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.busy) busy_cnt++;
      end
   end

   task automatic clr_stats();
      enable_cnt = 0; done_cnt = 0; busy_cnt = 0;
      first_en = -1; last_en = -1; done_cyc = -1;
      cap.delete();
   endtask

   task automatic push_expected(input int n);
      for (int j = 0; j < n + SIZE - 1; j++) begin
         vec_t e;
         for (int k = 0; k < SIZE; k++) begin
            e[k] = (j - k >= 0 && j - k < n) ? stim_beats[j-k][k] : 16'd0;
         end
         sb.push_back(e);
      end
   endtask

   task automatic send_stream(input int n);
      push_expected(n);
      for (int i = 0; i < n; i++) begin
         bit r, d, ok;
         if (stim_gap[i] > 0) begin
            bus.in_valid = 1'b0;
            repeat (stim_gap[i]) @(posedge clk);
            #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = stim_beats[i];
         bus.in_last  = (i == n - 1);
         ok = 1'b0;
         for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            r = bus.in_ready;
            d = bus.done;
            @(posedge clk);
            #1;
            if (r) begin
               ok = 1'b1;
               break;
            end
         end
         if (!ok) begin
            chk("handshake_timeout", 64'd0, 64'd1);
            break;
         end
         if (i == 0) first_accept_done = d;
`ifdef HS_NPU_FEEDER_BEAT_COUNT_EN
         if (bc_check) chk("beat_count_run", 64'(bus.beat_count), 64'(i + 1));
`endif
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 64'd0, 64'd1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic load_seq(input int n);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < SIZE; k++) stim_beats[i][k] = 16'(SIZE * i + k + 1);
         stim_gap[i] = 0;
      end
   endtask

   task automatic load_rand(input int n);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < SIZE; k++) stim_beats[i][k] = 16'($urandom);
         stim_gap[i] = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t tbl[6];
      tbl[0] = '{16'd1, 16'd0};
      tbl[1] = '{16'd5, 16'd0};
      tbl[2] = '{16'd9, 16'd0};
      tbl[3] = '{16'd0, 16'd4};
      tbl[4] = '{16'd0, 16'd8};
      tbl[5] = '{16'd0, 16'd12};

      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", bus.out_data, 64'd0);
      chk("rst_enable", 64'(bus.enable_out), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_ready", 64'(bus.in_ready), 64'd1);

      // 3 back-to-back beats, compared against the hand-derived table
      clr_stats();
      load_seq(3);
      send_stream(3);
      wait_done();
      chk("t1_enables", 64'(enable_cnt), 64'd6);
      chk("t1_done_cnt", 64'(done_cnt), 64'd1);
      chk("t1_done_at_last_en", 64'(done_cyc), 64'(last_en));
      for (int i = 0; i < 6; i++) begin
         if (i < cap.size()) begin
            chk($sformatf("t1_lane0_%0d", i), 64'(cap[i][0]), 64'(tbl[i].exp_lane0));
            chk($sformatf("t1_lane3_%0d", i), 64'(cap[i][3]), 64'(tbl[i].exp_lane3));
         end else begin
            chk("t1_capture_short", 64'(cap.size()), 64'd6);
         end
      end

      // Two stall cycles between beats 1 and 2
      clr_stats();
      load_seq(3);
      stim_gap[1] = 2;
      send_stream(3);
      wait_done();
      chk("t2_enables", 64'(enable_cnt), 64'd6);
      chk("t2_span", 64'(last_en - first_en), 64'd7);

      // Single beat with in_last
      clr_stats();
      load_rand(1);
      send_stream(1);
      wait_done();
      chk("t3_enables", 64'(enable_cnt), 64'd4);
      chk("t3_busy", 64'(busy_cnt), 64'd3);
      chk("t3_done_cnt", 64'(done_cnt), 64'd1);

      // Reset asserted mid-flush
      load_rand(2);
      send_stream(2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out", bus.out_data, 64'd0);
      chk("mid_rst_enable", 64'(bus.enable_out), 64'd0);
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_ready", 64'(bus.in_ready), 64'd0);
      sb.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      clr_stats();
      load_seq(3);
      send_stream(3);
      wait_done();
      chk("post_rst_enables", 64'(enable_cnt), 64'd6);
      chk("post_rst_done_cnt", 64'(done_cnt), 64'd1);

      // Next stream held valid through flush
      clr_stats();
      load_rand(2);
      send_stream(2);
      load_rand(3);
      send_stream(3);
      chk("held_first_on_done", 64'(first_accept_done), 64'd1);
      wait_done();
      chk("held_enables", 64'(enable_cnt), 64'd11);
      chk("held_done_cnt", 64'(done_cnt), 64'd2);

`ifdef HS_NPU_FEEDER_BEAT_COUNT_EN
      bc_check = 1'b1;
      load_rand(5);
      send_stream(5);
      wait_done();
      chk("beat_count_hold", 64'(bus.beat_count), 64'd5);
      load_rand(2);
      send_stream(2);
      wait_done();
      chk("beat_count_restart", 64'(bus.beat_count), 64'd2);
      bc_check = 1'b0;
`endif

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
